// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [NUM_REQ-1:0]            rvalid;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          busy;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rdata, rvalid, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rdata, rvalid, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port token memory between NUM_REQ
// requesters. A grant is held for a burst while its requester keeps req high,
// and is forcibly released after BURST_MAX accesses so nobody starves.
// Handover to the next requester happens on the releasing edge (no bubble).
// Optional per-requester access counters: define MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef MEM_PORT_ARBITER_STATS_EN
  input  logic                   stats_clr,
  output logic [NUM_REQ*16-1:0]  grant_count,
`endif
  mem_port_arbiter_if.slave      bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                state;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    rvalid_q;
  logic [IW-1:0]         own;
  logic [IW-1:0]         ptr;
  logic [CW-1:0]         bcnt;

  logic                  own_req;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  access;
  logic [CW-1:0]         bcnt_inc;
  logic                  burst_done;
  logic                  release_now;
  logic [IW-1:0]         own_plus1;
  logic [IW-1:0]         search_start;
  logic                  found;
  logic [IW-1:0]         pick;

  // Select the current owner's request, write enable, address and data slice
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (own == IW'(i)) begin
        own_req   = bus.req[i];
        own_we    = bus.we[i];
        own_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // An access happens only while owning the port and the owner still requests
  always_comb begin
    access      = (state == OWNED) && own_req;
    bcnt_inc    = bcnt + CW'(1);
    burst_done  = access && (bcnt_inc == CW'(BURST_MAX));
    release_now = (state == OWNED) && (!own_req || burst_done);
    own_plus1   = (own == IW'(NUM_REQ - 1)) ? '0 : own + IW'(1);
  end

  // Cyclic priority search; after a release the releaser sits last in order,
  // so it only wins again when nobody else is requesting
  always_comb begin
    search_start = (state == OWNED) ? own_plus1 : ptr;
    found        = 1'b0;
    pick         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req[i] && (((int'(search_start) + k) % NUM_REQ) == i)) begin
          found = 1'b1;
          pick  = IW'(i);
        end
      end
    end
  end

  // Arbitration FSM with registered grant, read-valid, pointer and burst count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      own      <= '0;
      ptr      <= '0;
      bcnt     <= '0;
    end else begin
      rvalid_q <= (access && !own_we) ? (ONE << own) : '0;
      case (state)
        IDLE: begin
          if (found) begin
            state <= OWNED;
            gnt_q <= ONE << pick;
            own   <= pick;
            bcnt  <= '0;
          end
        end
        OWNED: begin
          if (release_now) begin
            ptr  <= own_plus1;
            bcnt <= '0;
            if (found) begin
              gnt_q <= ONE << pick;
              own   <= pick;
            end else begin
              state <= IDLE;
              gnt_q <= '0;
            end
          end else if (access) begin
            bcnt <= bcnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Memory-side strobes are combinational from the registered grant and inputs
  always_comb begin
    bus.gnt       = gnt_q;
    bus.rvalid    = rvalid_q;
    bus.rdata     = bus.mem_rdata;
    bus.busy      = |gnt_q;
    bus.mem_en    = access;
    bus.mem_we    = access && own_we;
    bus.mem_addr  = access ? own_addr  : '0;
    bus.mem_wdata = access ? own_wdata : '0;
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [NUM_REQ*16-1:0] count_q;

  // Saturating per-requester access counters; a clear beats an increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (stats_clr) begin
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (access && (own == IW'(i)) && (count_q[i*16 +: 16] != 16'hFFFF)) begin
          count_q[i*16 +: 16] <= count_q[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign grant_count = count_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Instance A uses BURST_MAX=16 with a
// small memory model; instance B uses BURST_MAX=2 for round-robin ordering.
// Build with MEM_PORT_ARBITER_STATS_EN defined to also exercise the counters.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_a ();
  mem_port_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_b ();

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic        stats_clr_a;
  logic        stats_clr_b;
  logic [63:0] grant_count_a;
  logic [63:0] grant_count_b;
`endif

  mem_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8), .BURST_MAX(16)) dut_a (
    .clk         (clk),
    .rst         (rst),
`ifdef MEM_PORT_ARBITER_STATS_EN
    .stats_clr   (stats_clr_a),
    .grant_count (grant_count_a),
`endif
    .bus         (bus_a)
  );

  mem_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8), .BURST_MAX(2)) dut_b (
    .clk         (clk),
    .rst         (rst),
`ifdef MEM_PORT_ARBITER_STATS_EN
    .stats_clr   (stats_clr_b),
    .grant_count (grant_count_b),
`endif
    .bus         (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model for instance A: 1-cycle read latency, reloaded during reset
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i + 8'h0D);
    end else if (bus_a.mem_en) begin
      if (bus_a.mem_we) mem[bus_a.mem_addr] <= bus_a.mem_wdata;
      else              bus_a.mem_rdata     <= mem[bus_a.mem_addr];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus_a.req = 4'hF;
    bus_b.req = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt_a: got %b expected %b", bus_a.gnt, 4'b0000); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_a: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en_a: got %b expected 0", bus_a.mem_en); end
    checks++; if (bus_a.rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rvalid_a: got %b expected 0000", bus_a.rvalid); end
    checks++; if (bus_b.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt_b: got %b expected 0000", bus_b.gnt); end
    bus_a.req = 4'h0;
    bus_b.req = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL idle_gnt_a: got %b expected 0000", bus_a.gnt); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus_a.req = 4'b0010;
    bus_a.we  = 4'b0000;
    bus_a.addr[4 +: 4] = 4'd3;
    #1;
    checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL single_gnt_latency: got %b expected 0000", bus_a.gnt); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus_a.addr[4 +: 4] = 4'(3 + k);
      #1;
      checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("[TB] FAIL single_gnt[%0d]: got %b expected 0010", k, bus_a.gnt); end
      checks++; if (bus_a.mem_en !== 1'b1 || bus_a.mem_addr !== 4'(3 + k)) begin errors++; $display("[TB] FAIL single_mem[%0d]: got en=%b addr=%0d expected en=1 addr=%0d", k, bus_a.mem_en, bus_a.mem_addr, 3 + k); end
      if (k > 0) begin
        checks++; if (bus_a.rvalid !== 4'b0010 || bus_a.rdata !== 8'(8'h10 + k - 1)) begin errors++; $display("[TB] FAIL single_rdata[%0d]: got rv=%b data=%h expected rv=0010 data=%h", k, bus_a.rvalid, bus_a.rdata, 8'(8'h10 + k - 1)); end
      end
    end
    @(negedge clk);
    bus_a.req = 4'b0000;
    #1;
    checks++; if (bus_a.rvalid !== 4'b0010 || bus_a.rdata !== 8'h14) begin errors++; $display("[TB] FAIL single_last_rdata: got rv=%b data=%h expected rv=0010 data=14", bus_a.rvalid, bus_a.rdata); end
    checks++; if (bus_a.gnt !== 4'b0010 || bus_a.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL single_drop_cycle: got gnt=%b en=%b expected gnt=0010 en=0", bus_a.gnt, bus_a.mem_en); end
    @(negedge clk);
    #1;
    checks++; if (bus_a.gnt !== 4'b0000 || bus_a.busy !== 1'b0 || bus_a.rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL single_release: got gnt=%b busy=%b rv=%b expected 0000/0/0000", bus_a.gnt, bus_a.busy, bus_a.rvalid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [6];
    order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    @(negedge clk);
    bus_b.req = 4'b1011;
    bus_b.we  = 4'b0000;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      #1;
      checks++; if (bus_b.gnt !== order[j/2] || bus_b.mem_en !== 1'b1) begin errors++; $display("[TB] FAIL rr_cycle[%0d]: got gnt=%b en=%b expected gnt=%b en=1", j, bus_b.gnt, bus_b.mem_en, order[j/2]); end
    end
    @(negedge clk);
    bus_b.req = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus_b.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rr_idle: got %b expected 0000", bus_b.gnt); end
  endtask

  task automatic test_lone_forced();
    int granted;
    int accesses;
    int reads;
    granted = 0;
    accesses = 0;
    reads = 0;
    @(negedge clk);
    bus_a.req = 4'b0100;
    bus_a.we  = 4'b0000;
    bus_a.addr[8 +: 4] = 4'd2;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (bus_a.gnt === 4'b0100) granted++;
      if (bus_a.mem_en === 1'b1) accesses++;
      if (bus_a.rvalid === 4'b0100) reads++;
    end
    checks++; if (granted != 40) begin errors++; $display("[TB] FAIL lone_granted: got %0d expected 40", granted); end
    checks++; if (accesses != 40) begin errors++; $display("[TB] FAIL lone_accesses: got %0d expected 40", accesses); end
    checks++; if (reads != 39) begin errors++; $display("[TB] FAIL lone_rvalid: got %0d expected 39", reads); end
    @(negedge clk);
    bus_a.req = 4'b0000;
    @(negedge clk);
    #1;
    checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL lone_release: got %b expected 0000", bus_a.gnt); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus_a.req = 4'b0001;
    bus_a.we  = 4'b0001;
    bus_a.addr[0 +: 4]  = 4'd9;
    bus_a.wdata[0 +: 8] = 8'hAB;
    @(negedge clk);
    #1;
    checks++; if (bus_a.gnt !== 4'b0001 || bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 4'd9 || bus_a.mem_wdata !== 8'hAB) begin errors++; $display("[TB] FAIL wr_access: got gnt=%b we=%b addr=%0d data=%h expected 0001/1/9/ab", bus_a.gnt, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata); end
    @(negedge clk);
    bus_a.req = 4'b1000;
    bus_a.we  = 4'b0000;
    bus_a.addr[12 +: 4] = 4'd9;
    #1;
    checks++; if (bus_a.mem_en !== 1'b0 || bus_a.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL wr_release_cycle: got en=%b we=%b expected 0/0", bus_a.mem_en, bus_a.mem_we); end
    @(negedge clk);
    #1;
    checks++; if (bus_a.gnt !== 4'b1000 || bus_a.mem_en !== 1'b1 || bus_a.mem_we !== 1'b0 || bus_a.mem_addr !== 4'd9) begin errors++; $display("[TB] FAIL rd_access: got gnt=%b en=%b we=%b addr=%0d expected 1000/1/0/9", bus_a.gnt, bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr); end
    @(negedge clk);
    bus_a.req = 4'b0000;
    #1;
    checks++; if (bus_a.rvalid !== 4'b1000 || bus_a.rdata !== 8'hAB) begin errors++; $display("[TB] FAIL rd_data: got rv=%b data=%h expected 1000/ab", bus_a.rvalid, bus_a.rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    bus_a.req = 4'b0001;
    bus_a.we  = 4'b0000;
    bus_a.addr[0 +: 4] = 4'd0;
    bus_a.addr[4 +: 4] = 4'd1;
    @(negedge clk);
    bus_a.req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus_a.gnt !== 4'b0010 || bus_a.mem_en !== 1'b1 || bus_a.rvalid !== 4'b0010) begin errors++; $display("[TB] FAIL rst_pre: got gnt=%b en=%b rv=%b expected 0010/1/0010", bus_a.gnt, bus_a.mem_en, bus_a.rvalid); end
    rst = 1'b1;
    bus_a.req = 4'b0011;
    #1;
    checks++; if (bus_a.gnt !== 4'b0000 || bus_a.rvalid !== 4'b0000 || bus_a.mem_en !== 1'b0 || bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid: got gnt=%b rv=%b en=%b busy=%b expected all zero", bus_a.gnt, bus_a.rvalid, bus_a.mem_en, bus_a.busy); end
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus_a.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rst_ptr: got %b expected 0001", bus_a.gnt); end
    bus_a.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

`ifdef MEM_PORT_ARBITER_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    stats_clr_a = 1'b1;
    @(negedge clk);
    stats_clr_a = 1'b0;
    bus_a.req = 4'b0001;
    bus_a.we  = 4'b0000;
    repeat (4) @(negedge clk);
    bus_a.req = 4'b0100;
    repeat (8) @(negedge clk);
    bus_a.req = 4'b0000;
    #1;
    checks++; if (grant_count_a !== {16'd0, 16'd7, 16'd0, 16'd3}) begin errors++; $display("[TB] FAIL stats_count: got %h expected %h", grant_count_a, {16'd0, 16'd7, 16'd0, 16'd3}); end
    stats_clr_a = 1'b1;
    @(negedge clk);
    stats_clr_a = 1'b0;
    #1;
    checks++; if (grant_count_a !== 64'd0) begin errors++; $display("[TB] FAIL stats_clear: got %h expected 0", grant_count_a); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_a.req = '0; bus_a.we = '0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.req = '0; bus_b.we = '0; bus_b.addr = '0; bus_b.wdata = '0;
    bus_b.mem_rdata = '0;
`ifdef MEM_PORT_ARBITER_STATS_EN
    stats_clr_a = 1'b0;
    stats_clr_b = 1'b0;
`endif
    test_reset();
    test_single_read();
    test_round_robin();
    test_lone_forced();
    test_write_read();
    test_reset_mid_burst();
`ifdef MEM_PORT_ARBITER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
